// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: FSM state type and default configuration shared by pulse_arb.
package pulse_arb_pkg;
    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 255;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_e;
endpackage

// File: rtl/pulse_arb_req_edge_det.sv
// req_edge_det: registers each request level and flags 0->1 transitions.
module req_edge_det #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] lvl_q;
    always_ff @(posedge clk) lvl_q <= rst ? '0 : lvl_i;
    // Previous sample clears on reset, so a level already high afterwards counts as an edge.
    assign rise_o = lvl_i & ~lvl_q;
endmodule

// File: rtl/pulse_arb.sv
// pulse_arb: round-robin arbiter turning request edges into one-cycle start strobes.
// Define PULSE_ARB_TIMEOUT_EN to abandon grants whose resource never goes busy.
module pulse_arb import pulse_arb_pkg::*; #(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ_LVL,
    input  logic                       RES_BUSY,
    output logic                       START_PULSE,
    output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
    output logic [NUM_REQ-1:0]         PENDING,
    output logic                       TIMEOUT_ERR
);
    localparam int IW = $clog2(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("pulse_arb: parameter out of range");
    end
    arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0] rise, clr, pending_q, pending_d;
    logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
    req_edge_det #(.W(NUM_REQ)) u_edge (
        .clk    (CLK),
        .rst    (RST),
        .lvl_i  (REQ_LVL),
        .rise_o (rise)
    );
    // Scan downward so the pending index closest after the pointer is the last one written.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending_q[IW'((int'(ptr_q) + k) % NUM_REQ)]) win = IW'((int'(ptr_q) + k) % NUM_REQ);
        end
    end
`ifdef PULSE_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic tmo, err_q;
    assign tmo = (state_q == WAIT_BUSY) && !RES_BUSY && (cnt_q == 16'(TIMEOUT_CYC - 1));
    always_ff @(posedge CLK) begin
        cnt_q <= (RST || state_q != WAIT_BUSY) ? '0 : cnt_q + 1'b1;
        err_q <= !RST && tmo;
    end
    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        clr     = '0;
        case (state_q)
            IDLE: if (|pending_q) begin
                state_d = ISSUE;
                grant_d = win;
                ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                clr     = NUM_REQ'(1) << win;
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (RES_BUSY) state_d = WAIT_DONE;
`ifdef PULSE_ARB_TIMEOUT_EN
                else if (tmo) state_d = IDLE;
`endif
            end
            WAIT_DONE: if (!RES_BUSY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // A fresh edge outranks the grant's clear of the same bit.
    assign pending_d = (pending_q & ~clr) | rise;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
        end
    end
    assign START_PULSE = (state_q == ISSUE);
    assign GRANT_ID    = grant_q;
    assign PENDING     = pending_q;
endmodule

// File: tb/tb_pulse_arb.sv
// tb_pulse_arb: directed checks of pulse_arb with hand-computed expectations.
module tb_pulse_arb;
    import pulse_arb_pkg::*;
    logic clk = 1'b0, rst = 1'b1, busy = 1'b0;
    logic [3:0] req = '0;
    logic start, terr;
    logic [1:0] gid;
    logic [3:0] pend;
    int checks = 0, errors = 0, cyc_n = 0;
    int gids[$];
    int starts[$];

    pulse_arb #(.NUM_REQ(4), .TIMEOUT_CYC(5)) dut (
        .CLK(clk), .RST(rst), .REQ_LVL(req), .RES_BUSY(busy),
        .START_PULSE(start), .GRANT_ID(gid), .PENDING(pend), .TIMEOUT_ERR(terr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (start) begin
            gids.push_back(int'(gid));
            starts.push_back(cyc_n);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!start && n < 20);
        chk(tag, 32'(start), 1);
    endtask

    task automatic serve(input int d, input int b);
        repeat (d) tick();
        busy = 1'b1;
        repeat (b) tick();
        busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        busy = 1'b0;
        tick();
        rst = 1'b0;
        gids.delete();
        starts.delete();
    endtask

    initial begin
        logic [1:0] g;
        tick();
        tick();
        chk("rst_start", 32'(start), 0);
        chk("rst_gid", 32'(gid), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_terr", 32'(terr), 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        gids.delete();
        starts.delete();
        // single request held for ~10 cycles, resource busy 3 cycles after the strobe
        req = 4'b0001;
        tick();
        chk("single_pend", 32'(pend), 4'b0001);
        chk("single_nostart", 32'(start), 0);
        tick();
        chk("single_start", 32'(start), 1);
        chk("single_gid", 32'(gid), 0);
        chk("single_pend_clr", 32'(pend), 0);
        serve(3, 2);
        tick();
        chk("single_idle", 32'(dut.state_q), 32'(IDLE));
        chk("single_pend_end", 32'(pend), 0);
        req = '0;
        tick();
        chk("single_pulses", starts.size(), 1);
        // four simultaneous edges served in index order
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_start("sim_start");
            serve(1, 2);
        end
        tick();
        chk("sim_pulses", gids.size(), 4);
        for (int i = 0; i < 4; i++) chk("sim_order", (i < gids.size()) ? gids[i] : -1, i);
        for (int i = 1; i < 4; i++) chk("sim_gap", (i < starts.size()) ? starts[i] - starts[i-1] : -1, 5);
        chk("sim_pend_end", 32'(pend), 0);
        chk("sim_idle", 32'(dut.state_q), 32'(IDLE));
        // requesters 0 and 2 re-pulse right after each grant
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_start("rr_start");
            g = gid;
            req[g] = 1'b0;
            tick();
            req[g] = 1'b1;
            busy = 1'b1;
            tick();
            tick();
            busy = 1'b0;
        end
        chk("rr_count", gids.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", (i < gids.size()) ? gids[i] : -1, (i % 2) * 2);
        // edge on requester 1 lands on the cycle its pending bit is granted
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0011;
        tick();
        chk("col_first_start", 32'(start), 1);
        chk("col_first_gid", 32'(gid), 0);
        chk("col_first_pend", 32'(pend), 4'b0010);
        req = 4'b0001;
        serve(1, 2);
        tick();
        chk("col_idle", 32'(dut.state_q), 32'(IDLE));
        chk("col_pend_before", 32'(pend), 4'b0010);
        req = 4'b0011;
        tick();
        chk("col_grant_start", 32'(start), 1);
        chk("col_grant_gid", 32'(gid), 1);
        chk("col_set_wins", 32'(pend), 4'b0010);
        serve(1, 2);
        wait_start("col_second_start");
        chk("col_second_gid", 32'(gid), 1);
        chk("col_second_pend", 32'(pend), 0);
        // reset clears a non-zero grant; busy while idle is ignored
        do_reset();
        chk("rst_gid_cleared", 32'(gid), 0);
        busy = 1'b1;
        repeat (3) tick();
        chk("busy_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("busy_idle_start", starts.size(), 0);
        busy = 1'b0;
        // resource never goes busy
        do_reset();
        req = 4'b0001;
        wait_start("to_start");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_wait_terr", 32'(terr), 0);
            chk("to_wait_state", 32'(dut.state_q), 32'(WAIT_BUSY));
        end
        tick();
`ifdef PULSE_ARB_TIMEOUT_EN
        chk("to_terr_pulse", 32'(terr), 1);
        chk("to_back_idle", 32'(dut.state_q), 32'(IDLE));
        tick();
        chk("to_terr_drop", 32'(terr), 0);
        chk("to_no_retry", starts.size(), 1);
`else
        chk("to_terr_tied", 32'(terr), 0);
        chk("to_still_wait", 32'(dut.state_q), 32'(WAIT_BUSY));
        tick();
        chk("to_terr_tied2", 32'(terr), 0);
        chk("to_still_wait2", 32'(dut.state_q), 32'(WAIT_BUSY));
`endif
        // reset while the resource is busy with two requests still pending
        do_reset();
        req = 4'b0111;
        wait_start("mid_start");
        tick();
        busy = 1'b1;
        tick();
        chk("mid_state", 32'(dut.state_q), 32'(WAIT_DONE));
        chk("mid_pend", 32'(pend), 4'b0110);
        rst = 1'b1;
        req = '0;
        tick();
        chk("mid_rst_start", 32'(start), 0);
        chk("mid_rst_gid", 32'(gid), 0);
        chk("mid_rst_pend", 32'(pend), 0);
        chk("mid_rst_terr", 32'(terr), 0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        busy = 1'b0;
        repeat (5) tick();
        chk("mid_no_reissue", starts.size(), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_arb.md
PULSE_ARB -- requirements
Module: pulse_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of level requesters (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum cycles spent waiting for RES_BUSY to rise (range 1..65535).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 REQ_LVL  input  NUM_REQ  SHALL be the level request lines, one per requester.
REQ-006 RES_BUSY  input  1  SHALL be the busy flag of the shared resource.
REQ-007 START_PULSE  output  1  SHALL be the one-cycle start strobe to the shared resource.
REQ-008 GRANT_ID  output  clog2(NUM_REQ)  SHALL be the index of the requester being served.
REQ-009 PENDING  output  NUM_REQ  SHALL be the captured-but-unserved request bits.
REQ-010 TIMEOUT_ERR  output  1  SHALL be a one-cycle strobe flagging a resource that never went busy.

Function
REQ-011 Each REQ_LVL bit SHALL be registered; a rising edge is REQ_LVL[i]=1 with the previous sample 0.
- Only edges count; a held level SHALL raise no further requests.
REQ-012 A detected edge SHALL set PENDING[i], visible in the cycle after the edge is sampled.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE -> ISSUE when PENDING is non-zero; otherwise remain in IDLE.
- On this transition, the winning index is loaded into GRANT_ID and its PENDING bit is cleared.
REQ-015 Winner selection SHALL be round-robin: search starts at the index after the last grant, wrapping from NUM_REQ-1 to 0.
- After reset the search starts at index 0.
REQ-016 START_PULSE SHALL be high for exactly the single cycle the FSM is in ISSUE; ISSUE -> WAIT_BUSY unconditionally.
REQ-017 WAIT_BUSY -> WAIT_DONE when RES_BUSY is sampled 1.
REQ-018 WAIT_DONE -> IDLE when RES_BUSY is sampled 0.
REQ-019 Latency: PENDING visible in cycle N with the FSM in IDLE -> START_PULSE high in cycle N+1.
- At least one IDLE cycle SHALL separate consecutive grants.
REQ-020 If an edge on requester i coincides with the clearing of PENDING[i], the set SHALL win and PENDING[i] remains 1.
REQ-021 A second edge on an already-pending requester SHALL be absorbed; there is no counting.
REQ-022 GRANT_ID SHALL hold its value from ISSUE until the next grant.
REQ-023 RES_BUSY high while in IDLE SHALL have no effect on the FSM.

Reset
REQ-024 With RST sampled high, the following SHALL occur:
- FSM returns to IDLE.
- PENDING=0, START_PULSE=0, GRANT_ID=0, TIMEOUT_ERR=0.
- Round-robin pointer selects index 0.
- Edge registers load 0, so a level already high after reset counts as an edge.
REQ-025 Reset mid-operation (any state) SHALL abort the transaction with no START_PULSE re-issue.

Configuration
REQ-026 Macro PULSE_ARB_TIMEOUT_EN defined:
- A counter in WAIT_BUSY runs; if RES_BUSY is not seen high within TIMEOUT_CYC cycles, TIMEOUT_ERR pulses for one cycle and the FSM returns to IDLE.
- The grant is dropped and not retried.
REQ-027 Macro PULSE_ARB_TIMEOUT_EN undefined:
- No counter is built; TIMEOUT_ERR is tied to 0.
- WAIT_BUSY waits indefinitely.

Structure
REQ-028 Package pulse_arb_pkg SHALL hold the FSM state type and the default NUM_REQ/TIMEOUT_CYC constants.
REQ-029 Sub-module req_edge_det SHALL hold the per-bit level register and rising-edge logic, instantiated once, NUM_REQ wide.

Verification
REQ-030 Single request: REQ_LVL=4'b0001 held 10 cycles, RES_BUSY high 3 cycles after START_PULSE.
- Expect: one START_PULSE, GRANT_ID=0, PENDING returns to 0, FSM back in IDLE.
REQ-031 Simultaneous requests: REQ_LVL 0 -> 4'b1111 in one cycle, resource busy 2 cycles per grant.
- Expect: grants in order 0,1,2,3, four START_PULSEs, each separated by at least one IDLE cycle.
REQ-032 Round-robin fairness: requesters 0 and 2 re-pulse immediately after each grant.
- Expect: GRANT_ID alternates 0,2,0,2; neither requester is served twice in a row.
REQ-033 Set/clear collision: edge on REQ_LVL[1] in the same cycle as its grant.
- Expect: PENDING[1] stays 1 and a second grant to 1 follows.
REQ-034 Timeout (PULSE_ARB_TIMEOUT_EN, TIMEOUT_CYC=5): RES_BUSY held 0.
- Expect: TIMEOUT_ERR high one cycle exactly 5 cycles after entering WAIT_BUSY, then IDLE.
- With the macro undefined, the FSM stays in WAIT_BUSY and TIMEOUT_ERR stays 0.
REQ-035 Reset mid-busy: RST high during WAIT_DONE with PENDING=4'b0110.
- Expect: all outputs 0 next cycle, FSM in IDLE, no spurious START_PULSE after release while REQ_LVL=0.
